// File: rtl/wshb_pkg.sv
// Shared Wishbone B4 constants and the slave state encoding.
package wshb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    BURST = 2'd3
  } slave_state_t;

  // Only a linear incrementing burst gets the pipelined path; everything else is classic.
  function automatic logic is_linear_incr(input logic [2:0] cti, input logic [1:0] bte);
    return (cti == CTI_INCR) && (bte == BTE_LINEAR);
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle shared by the framebuffer masters and the RAM slave.
interface wshb_if;
  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack;

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, dat_ms, cti, bte,
    output dat_sm, ack
  );

  modport master (
    input  clk, rst, dat_sm, ack,
    output cyc, stb, we, adr, sel, dat_ms, cti, bte
  );
endinterface

// File: rtl/bram_be.sv
// 32-bit block RAM with per-byte write enables and a registered (1-cycle) read; no reset.
module bram_be #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic [3:0]            i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [31:0]           i_wdat,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [31:0]           o_rdat
);

  logic [31:0] r_mem [2**ADDR_WIDTH];
  logic [31:0] r_rdat;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_waddr][8*i +: 8] <= i_wdat[8*i +: 8];
    end
    r_rdat <= r_mem[i_raddr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 slave over byte-enable RAM: classic cycles after WAIT_STATES wait states,
// linear incrementing bursts at one beat per cycle with the next word prefetched.
module wshb_ram_slave
  import wshb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  wshb_if.slave wshb_ifs
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_t          r_state;
  logic [3:0]            r_cnt;
  logic                  r_burst;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_dat;

  logic                  w_req;
  logic                  w_incr;
  logic                  w_ack;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [3:0]            w_be;
  logic [31:0]           w_rdat;
  logic                  w_unused_adr;

  assign w_req        = wshb_ifs.cyc & wshb_ifs.stb;
  assign w_idx        = wshb_ifs.adr[ADDR_WIDTH+1:2];
  assign w_incr       = is_linear_incr(wshb_ifs.cti, wshb_ifs.bte);
  assign w_unused_adr = ^{wshb_ifs.adr[31:ADDR_WIDTH+2], wshb_ifs.adr[1:0]};

  assign w_ack = ((r_state == ACK) || (r_state == BURST)) && w_req;
  assign w_be  = (w_ack && wshb_ifs.we) ? wshb_ifs.sel : 4'b0000;

  // The read issued on the edge that enters ACK/BURST is what the ack cycle presents.
  always_comb begin
    w_raddr = w_idx;
    case (r_state)
      WAIT:    w_raddr = r_addr;
      BURST:   w_raddr = r_addr + 1'b1;
      default: w_raddr = w_idx;
    endcase
  end

  bram_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .i_clk   (wshb_ifs.clk),
    .i_we    (w_be),
    .i_waddr (w_idx),
    .i_wdat  (wshb_ifs.dat_ms),
    .i_raddr (w_raddr),
    .o_rdat  (w_rdat)
  );

  always_ff @(posedge wshb_ifs.clk) begin
    if (wshb_ifs.rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_burst <= 1'b0;
      r_addr  <= '0;
      r_dat   <= 32'd0;
    end else begin
      if (w_ack) r_dat <= w_rdat;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= w_idx;
            r_burst <= w_incr;
            if (WAIT_STATES > 0) begin
              r_state <= WAIT;
              r_cnt   <= WS_LOAD;
            end else begin
              r_state <= w_incr ? BURST : ACK;
            end
          end
        end
        WAIT: begin
          if (!w_req) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= r_burst ? BURST : ACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        BURST: begin
          if (!w_req || (wshb_ifs.cti == CTI_EOB)) begin
            r_state <= IDLE;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outside an ack the bus keeps showing the last word handed out.
  assign wshb_ifs.ack    = w_ack;
  assign wshb_ifs.dat_sm = w_ack ? w_rdat : r_dat;

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Directed bench for wshb_ram_slave: one instance with no wait states, one with three.
module tb_wshb_ram_slave;
  import wshb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  wshb_if b0 ();
  wshb_if b3 ();
  assign b0.clk = clk;
  assign b3.clk = clk;

  wshb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (.wshb_ifs(b0));
  wshb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (.wshb_ifs(b3));

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [2:0]  cti;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input int d, input logic c, input logic s, input logic we,
                     input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] wd,
                     input logic [2:0] cti);
    if (d == 0) begin
      b0.cyc = c; b0.stb = s; b0.we = we; b0.adr = adr;
      b0.sel = sel; b0.dat_ms = wd; b0.cti = cti; b0.bte = BTE_LINEAR;
    end else begin
      b3.cyc = c; b3.stb = s; b3.we = we; b3.adr = adr;
      b3.sel = sel; b3.dat_ms = wd; b3.cti = cti; b3.bte = BTE_LINEAR;
    end
  endtask

  function automatic logic get_ack(input int d);
    return (d == 0) ? b0.ack : b3.ack;
  endfunction

  function automatic logic [31:0] get_dat(input int d);
    return (d == 0) ? b0.dat_sm : b3.dat_sm;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One classic transfer; lat is the number of cycles from request to ack (-1 if none).
  task automatic classic(input int d, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] wd, input logic [2:0] cti,
                         output logic [31:0] rd, output int lat);
    rd  = 32'h0;
    lat = -1;
    drv(d, 1'b1, 1'b1, we, adr, sel, wd, cti);
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (get_ack(d)) begin
        lat = n;
        rd  = get_dat(d);
        break;
      end
    end
    @(posedge clk); #1;
    drv(d, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, CTI_CLASSIC);
  endtask

  // Linear burst on the zero-wait instance; beat k must ack on cycle k+1.
  task automatic burst(input string nm, input logic we, input logic [31:0] start,
                       input int len, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ex[4];
    int n;
    ex = '{e0, e1, e2, e3};
    n  = -1;
    drv(0, 1'b1, 1'b1, we, start, 4'hF, ex[0], (len == 1) ? CTI_EOB : CTI_INCR);
    for (int k = 0; k < len; k++) begin
      for (int t = 0; t < 8; t++) begin
        @(negedge clk);
        n++;
        if (b0.ack) break;
      end
      chk({nm, "_beat_cycle"}, 32'(n), 32'(k + 1));
      if (!we) chk({nm, "_beat_dat"}, b0.dat_sm, ex[k]);
      @(posedge clk); #1;
      if (k + 1 < len)
        drv(0, 1'b1, 1'b1, we, start + 32'(4 * (k + 1)), 4'hF, ex[k+1],
            (k + 2 == len) ? CTI_EOB : CTI_INCR);
    end
    // Request held after end-of-burst: slave must be back in IDLE, so no ack this cycle.
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    chk({nm, "_idle_after_eob"}, 32'(b0.ack), 32'd0);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, CTI_CLASSIC);
    idle_cycles(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          first, second, acks, consec, seen;
    logic        prev;

    tbl[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, CTI_CLASSIC, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        CTI_CLASSIC, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h11223344, CTI_CLASSIC, 32'h0};
    tbl[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABBCCDD, CTI_CLASSIC, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,        CTI_CLASSIC, 32'h11BB33DD};
    tbl[5]  = '{1'b1, 32'h0000_1010, 4'hF, 32'h55667788, CTI_CLASSIC, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,        CTI_CLASSIC, 32'h55667788};
    tbl[7]  = '{1'b1, 32'h0000_0020, 4'h0, 32'hFFFFFFFF, CTI_CLASSIC, 32'h0};
    tbl[8]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,        CTI_CLASSIC, 32'h11BB33DD};
    tbl[9]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        CTI_EOB,     32'h55667788};
    tbl[10] = '{1'b1, 32'h0000_0000, 4'hF, 32'h0,        CTI_CLASSIC, 32'h0};
    tbl[11] = '{1'b1, 32'h0000_0004, 4'hF, 32'h1,        CTI_CLASSIC, 32'h0};
    tbl[12] = '{1'b1, 32'h0000_0008, 4'hF, 32'h2,        CTI_CLASSIC, 32'h0};
    tbl[13] = '{1'b1, 32'h0000_000C, 4'hF, 32'h3,        CTI_CLASSIC, 32'h0};
    tbl[14] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'hC0FFEE00, CTI_CLASSIC, 32'h0};
    tbl[15] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,        CTI_CLASSIC, 32'hC0FFEE00};

    // Reset with a request pending: no ack, data bus zero.
    b0.rst = 1'b1;
    b3.rst = 1'b1;
    drv(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, CTI_CLASSIC);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, CTI_CLASSIC);
    idle_cycles(3);
    @(negedge clk);
    chk("reset_ack_ws0", 32'(b0.ack), 32'd0);
    chk("reset_dat_ws0", b0.dat_sm, 32'h0);
    chk("reset_ack_ws3", 32'(b3.ack), 32'd0);
    chk("reset_dat_ws3", b3.dat_sm, 32'h0);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, CTI_CLASSIC);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, CTI_CLASSIC);
    b0.rst = 1'b0;
    b3.rst = 1'b0;
    idle_cycles(2);

    // Classic transfers on the zero-wait instance.
    for (int i = 0; i < 16; i++) begin
      classic(0, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wd, tbl[i].cti, rd, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      if (!tbl[i].we) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
    end
    idle_cycles(1);

    // Bursts: plain read, wrap past the top word, write then read back.
    burst("burst_rd", 1'b0, 32'h0, 4, 32'h0, 32'h1, 32'h2, 32'h3);
    burst("burst_wrap", 1'b0, 32'hFFC, 3, 32'hC0FFEE00, 32'h0, 32'h1, 32'h0);
    burst("burst_wr", 1'b1, 32'h40, 2, 32'h11110000, 32'h22220000, 32'h0, 32'h0);
    burst("burst_rdback", 1'b0, 32'h40, 2, 32'h11110000, 32'h22220000, 32'h0, 32'h0);

    // Strobe dropped mid-burst: ack falls the same cycle, slave returns to IDLE.
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, CTI_INCR);
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (b0.ack) seen++;
      if (n < 2) begin
        @(posedge clk); #1;
        drv(0, 1'b1, 1'b1, 1'b0, 32'(4 * (n + 1)), 4'hF, 32'h0, CTI_INCR);
      end
    end
    chk("abort_burst_acks", 32'(seen), 32'd2);
    @(posedge clk); #1;
    drv(0, 1'b1, 1'b0, 1'b0, 32'h8, 4'hF, 32'h0, CTI_INCR);
    @(negedge clk);
    chk("abort_burst_ack_low", 32'(b0.ack), 32'd0);
    @(posedge clk); #1;
    classic(0, 1'b0, 32'h8, 4'hF, 32'h0, CTI_CLASSIC, rd, lat);
    chk("abort_burst_next_latency", 32'(lat), 32'd1);
    chk("abort_burst_next_rdata", rd, 32'h2);

    // Three wait states: single write, then two reads with strobe held.
    classic(1, 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, CTI_CLASSIC, rd, lat);
    chk("ws3_write_latency", 32'(lat), 32'd4);
    idle_cycles(1);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, CTI_CLASSIC);
    first = -1; second = -1; acks = 0; consec = 0; prev = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (b3.ack) begin
        acks++;
        if (prev) consec++;
        if (first < 0) first = n;
        else if (second < 0) second = n;
        chk("ws3_held_rdata", b3.dat_sm, 32'hA5A5A5A5);
      end
      prev = b3.ack;
    end
    @(posedge clk); #1;
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, CTI_CLASSIC);
    chk("ws3_first_ack_cycle", 32'(first), 32'd4);
    chk("ws3_second_ack_cycle", 32'(second), 32'd9);
    chk("ws3_ack_count", 32'(acks), 32'd2);
    chk("ws3_back_to_back_acks", 32'(consec), 32'd0);
    idle_cycles(2);

    // Reset during the wait of a write: aborted, word untouched, outputs cleared.
    drv(1, 1'b1, 1'b1, 1'b1, 32'h20, 4'hF, 32'hDEAD0000, CTI_CLASSIC);
    seen = 0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      if (b3.ack) seen++;
    end
    @(posedge clk); #1;
    b3.rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (b3.ack) seen++;
    end
    chk("rst_abort_ack", 32'(b3.ack), 32'd0);
    chk("rst_abort_dat", b3.dat_sm, 32'h0);
    @(posedge clk); #1;
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, CTI_CLASSIC);
    b3.rst = 1'b0;
    chk("rst_abort_no_ack_seen", 32'(seen), 32'd0);
    idle_cycles(1);
    classic(1, 1'b0, 32'h20, 4'hF, 32'h0, CTI_CLASSIC, rd, lat);
    chk("rst_abort_word_unchanged", rd, 32'hA5A5A5A5);
    chk("rst_abort_read_latency", 32'(lat), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
